// File: rtl/agg_pkg.sv
// Shared types and lane arithmetic helpers for the neighbour aggregator.
//   agg_state_t : FSM state encoding
//   sign_ext    : reinterpret the low w bits of v as signed and extend to MAX_W
//   sat_clamp   : clamp a signed MAX_W value to the signed range of w bits
package agg_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WRITE = 2'd2
  } agg_state_t;

  function automatic logic signed [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] v,
                                                        input int w);
    logic signed [MAX_W-1:0] t;
    t = signed'(v << (MAX_W - w));
    return t >>> (MAX_W - w);
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_clamp(input logic signed [MAX_W-1:0] acc,
                                                         input int w);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = signed'((MAX_W'(1) << (w - 1)) - MAX_W'(1));
    // In two's complement, ~(2^(w-1)-1) == -2^(w-1).
    lo = ~hi;
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/agg_lane_acc.sv
// Single-lane accumulator.
//   clk, rst : clock, async active-high reset
//   clr      : zero the accumulator (takes priority over add)
//   add      : add sign-extended din to the accumulator
//   din      : signed WIDTH-bit lane sample
//   sat      : accumulator clamped to the signed WIDTH range
module agg_lane_acc
  import agg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sat
);

  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + ACC_W'(sign_ext(MAX_W'(din), WIDTH));
    end
  end

  assign sat = WIDTH'(sat_clamp(sign_ext(MAX_W'(acc), ACC_W), WIDTH));

endmodule

// File: rtl/neighbor_aggregator.sv
// Neighbour aggregator: for each job, reads job_degree rows from the source
// scratchpad (0-cycle read port), sums them lane-wise with sign extension and
// writes the saturated row once to the destination scratchpad.
//   job_*   : job handshake (destination row, neighbour count)
//   nbr_*   : neighbour-address handshake, accepted only in ACCUM
//   src_*   : source scratchpad read port; src_qout is same-cycle data
//   dst_*   : destination scratchpad write port, active only in WRITE
//   busy    : not idle;  done : one-cycle pulse with dst_write_en
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | job_ready high; accept latches dst/degree, clears lanes
// ST_ACCUM | one neighbour row summed per nbr handshake
// ST_WRITE | single-cycle saturated write of the result row
module neighbor_aggregator
  import agg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PARALLELISM = 1,
  parameter int HEIGHT      = 128,
  parameter int MAX_DEG     = 255,
  localparam int AW         = $clog2(HEIGHT),
  localparam int DEG_W      = $clog2(MAX_DEG + 1),
  localparam int ACC_W      = WIDTH + DEG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [AW-1:0]                job_dst_addr,
  input  logic [DEG_W-1:0]             job_degree,
  input  logic                         nbr_valid,
  output logic                         nbr_ready,
  input  logic [AW-1:0]                nbr_addr,
  output logic                         src_cs,
  output logic [AW-1:0]                src_read_addr,
  output logic                         src_read_en,
  input  logic [PARALLELISM*WIDTH-1:0] src_qout,
  output logic                         dst_cs,
  output logic [AW-1:0]                dst_write_addr,
  output logic                         dst_write_en,
  output logic [PARALLELISM*WIDTH-1:0] dst_din,
  output logic                         busy,
  output logic                         done
);

  agg_state_t              state, state_nxt;
  logic [DEG_W-1:0]        remaining;
  logic [AW-1:0]           dst_addr_q;
  logic [PARALLELISM*WIDTH-1:0] lane_sat;
  logic                    accept;
  logic                    nbr_fire;

  assign accept   = (state == ST_IDLE) && job_valid;
  assign nbr_fire = (state == ST_ACCUM) && nbr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      dst_addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        remaining  <= job_degree;
        dst_addr_q <= job_dst_addr;
      end else if (nbr_fire) begin
        remaining  <= remaining - DEG_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    job_ready      = 1'b0;
    nbr_ready      = 1'b0;
    src_cs         = 1'b0;
    src_read_en    = 1'b0;
    src_read_addr  = '0;
    dst_cs         = 1'b0;
    dst_write_en   = 1'b0;
    dst_write_addr = '0;
    dst_din        = '0;
    done           = 1'b0;
    busy           = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          state_nxt = (job_degree != '0) ? ST_ACCUM : ST_WRITE;
        end
      end
      ST_ACCUM: begin
        nbr_ready     = 1'b1;
        src_cs        = 1'b1;
        src_read_addr = nbr_addr;
        src_read_en   = nbr_valid;
        // Terminal count: the handshake that consumes the last neighbour.
        if (nbr_valid && (remaining == DEG_W'(1))) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        dst_cs         = 1'b1;
        dst_write_en   = 1'b1;
        done           = 1'b1;
        dst_write_addr = dst_addr_q;
        dst_din        = lane_sat;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    agg_lane_acc #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .add (nbr_fire),
      .din (src_qout[i*WIDTH +: WIDTH]),
      .sat (lane_sat[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_neighbor_aggregator.sv
// Directed bench for neighbor_aggregator (WIDTH=8, PARALLELISM=2).
module tb_neighbor_aggregator;

  localparam int W  = 8;
  localparam int P  = 2;
  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [AW-1:0] job_dst_addr = '0;
  logic [DW-1:0] job_degree = '0;
  logic          nbr_valid = 1'b0;
  logic          nbr_ready;
  logic [AW-1:0] nbr_addr = '0;
  logic          src_cs;
  logic [AW-1:0] src_read_addr;
  logic          src_read_en;
  logic [P*W-1:0] src_qout;
  logic          dst_cs;
  logic [AW-1:0] dst_write_addr;
  logic          dst_write_en;
  logic [P*W-1:0] dst_din;
  logic          busy;
  logic          done;

  logic [P*W-1:0] mem [128];
  assign src_qout = mem[src_read_addr];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  neighbor_aggregator #(.WIDTH(W), .PARALLELISM(P), .HEIGHT(128), .MAX_DEG(255)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_dst_addr(job_dst_addr), .job_degree(job_degree),
    .nbr_valid(nbr_valid), .nbr_ready(nbr_ready), .nbr_addr(nbr_addr),
    .src_cs(src_cs), .src_read_addr(src_read_addr), .src_read_en(src_read_en),
    .src_qout(src_qout),
    .dst_cs(dst_cs), .dst_write_addr(dst_write_addr), .dst_write_en(dst_write_en),
    .dst_din(dst_din), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [AW-1:0]      dst;
    logic [DW-1:0]      deg;
    logic [3:0][AW-1:0] a;
    logic [7:0]         sched;   // bit c-1 : nbr_valid offered in cycle c
    logic [P*W-1:0]     exp_din;
    logic [7:0]         exp_lat;
  } vec_t;

  // Runs one job starting in the current cycle; checks write latency,
  // address, data, done, number of reads and job_ready afterwards.
  task automatic run_job(input string tag, input vec_t v);
    int cyc;
    int k;
    int reads;
    int wcyc;
    logic [AW-1:0]  waddr;
    logic [P*W-1:0] wdin;
    logic           wdone;
    cyc = 0; k = 0; reads = 0; wcyc = -1; waddr = '0; wdin = '0; wdone = 1'b0;
    job_valid    = 1'b1;
    job_dst_addr = v.dst;
    job_degree   = v.deg;
    #3;
    check({tag, " job_ready at offer"}, 32'(job_ready), 32'd1);
    tick();
    job_valid = 1'b0;
    job_dst_addr = '1;
    job_degree   = '1;
    cyc = 1;
    while (wcyc < 0 && cyc < 30) begin
      nbr_valid = (k < int'(v.deg)) && ((cyc > 8) || v.sched[cyc-1]);
      nbr_addr  = (k < 4) ? v.a[k] : '0;
      #3;
      if (src_read_en) reads++;
      if (dst_write_en) begin
        wcyc = cyc; waddr = dst_write_addr; wdin = dst_din; wdone = done;
      end
      if (nbr_valid && nbr_ready) k++;
      tick();
      cyc++;
    end
    nbr_valid = 1'b0;
    check({tag, " write cycle"}, 32'(wcyc), 32'(v.exp_lat));
    check({tag, " write addr"}, 32'(waddr), 32'(v.dst));
    check({tag, " dst_din"}, 32'(wdin), 32'(v.exp_din));
    check({tag, " done with write"}, 32'(wdone), 32'd1);
    check({tag, " reads"}, 32'(reads), 32'(v.deg));
    #3;
    check({tag, " job_ready after write"}, 32'(job_ready), 32'd1);
    tick();
  endtask

  vec_t vecs [5];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[3]  = 16'h0AFB;   // {10, -5}
    mem[7]  = 16'h1407;   // {20, 7}
    mem[10] = 16'h9C64;   // {-100, 100}
    mem[11] = 16'h9C64;
    mem[12] = 16'h9C64;

    //                dst     deg    neighbours {a3,a2,a1,a0}          sched         din        lat
    vecs[0] = '{7'd5,   8'd2, {7'd0,  7'd0,  7'd7,  7'd3},  8'hFF,       16'h1E02, 8'd3};
    vecs[1] = '{7'd20,  8'd3, {7'd0,  7'd12, 7'd11, 7'd10}, 8'hFF,       16'h807F, 8'd4};
    vecs[2] = '{7'd9,   8'd0, {7'd0,  7'd0,  7'd0,  7'd0},  8'hFF,       16'h0000, 8'd1};
    vecs[3] = '{7'd33,  8'd2, {7'd0,  7'd0,  7'd7,  7'd3},  8'b11111001, 16'h1E02, 8'd5};
    vecs[4] = '{7'd127, 8'd4, {7'd12, 7'd7,  7'd3,  7'd3},  8'hFF,       16'hC461, 8'd5};

    #2;
    check("reset job_ready", 32'(job_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset dst_write_en", 32'(dst_write_en), 32'd0);
    check("reset src_read_en", 32'(src_read_en), 32'd0);
    check("reset dst_din", 32'(dst_din), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_job($sformatf("vec%0d", i), vecs[i]);

    // Reset mid-job: degree 4, two neighbours accepted, then reset.
    job_valid = 1'b1; job_dst_addr = 7'd40; job_degree = 8'd4;
    tick();
    job_valid = 1'b0;
    nbr_valid = 1'b1; nbr_addr = 7'd3;
    tick();
    nbr_addr = 7'd7;
    tick();
    nbr_valid = 1'b0;
    #2;
    check("midjob busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midjob rst job_ready", 32'(job_ready), 32'd1);
    check("midjob rst busy", 32'(busy), 32'd0);
    check("midjob rst nbr_ready", 32'(nbr_ready), 32'd0);
    check("midjob rst src_cs", 32'(src_cs), 32'd0);
    check("midjob rst dst_write_en", 32'(dst_write_en), 32'd0);
    tick();
    rst = 1'b0;
    begin
      int wr;
      wr = 0;
      for (int i = 0; i < 4; i++) begin
        #3;
        if (dst_write_en) wr++;
        tick();
      end
      check("midjob no write after reset", 32'(wr), 32'd0);
    end
    run_job("post-reset", '{7'd41, 8'd1, {7'd0, 7'd0, 7'd0, 7'd7}, 8'hFF, 16'h1407, 8'd2});

    // Back-to-back degree-1 jobs with job_valid held high.
    job_valid = 1'b1; job_dst_addr = 7'd50; job_degree = 8'd1;
    #3; check("b2b accept1 ready", 32'(job_ready), 32'd1);
    tick();
    job_dst_addr = 7'd51;
    nbr_valid = 1'b1; nbr_addr = 7'd3;
    #3; check("b2b c1 job_ready low", 32'(job_ready), 32'd0);
    tick();
    nbr_valid = 1'b0;
    #3;
    check("b2b w1 en", 32'(dst_write_en), 32'd1);
    check("b2b w1 addr", 32'(dst_write_addr), 32'd50);
    check("b2b w1 din", 32'(dst_din), 32'h0AFB);
    tick();
    #3; check("b2b accept2 ready at c3", 32'(job_ready), 32'd1);
    tick();
    job_valid = 1'b0;
    nbr_valid = 1'b1; nbr_addr = 7'd7;
    #3; check("b2b c4 nbr_ready", 32'(nbr_ready), 32'd1);
    tick();
    nbr_valid = 1'b0;
    #3;
    check("b2b w2 en", 32'(dst_write_en), 32'd1);
    check("b2b w2 addr", 32'(dst_write_addr), 32'd51);
    check("b2b w2 din", 32'(dst_din), 32'h1407);
    tick();
    #3; check("b2b idle after", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neighbor_aggregator.md
Name: neighbor_aggregator

Overview:
- Downstream consumer of the feature scratchpad. For each aggregation job it reads one feature row per neighbour address through the scratchpad's 0-cycle read port 1.
- It sums all rows lane-wise with sign extension, saturates the sum to WIDTH, and writes the result row once to the destination scratchpad's write port.
- It sits between the job/neighbour-list front end and the output scratchpad of the aggregation engine.

Parameters:
- WIDTH, 8: signed bits per lane (matches the scratchpad).
- PARALLELISM, 1: lanes per row.
- HEIGHT, 128: rows per scratchpad; address width is clog2(HEIGHT).
- MAX_DEG, 255: maximum neighbours per job.
- Derived localparams: DEG_W = clog2(MAX_DEG+1); ACC_W = WIDTH + DEG_W.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- job_valid  in  1  job offered
- job_ready  out  1  block idle and accepting a job
- job_dst_addr  in  clog2(HEIGHT)  destination row
- job_degree  in  DEG_W  neighbour count, 0..MAX_DEG
- nbr_valid  in  1  neighbour address offered
- nbr_ready  out  1  neighbour accepted this cycle when nbr_valid is also high
- nbr_addr  in  clog2(HEIGHT)  source row address
- src_cs  out  1  source scratchpad chip select
- src_read_addr  out  clog2(HEIGHT)  to scratchpad read_addr_1
- src_read_en  out  1  to scratchpad read_en_1
- src_qout  in  PARALLELISM*WIDTH  from scratchpad qout_1; combinational, same cycle
- dst_cs  out  1  destination scratchpad chip select
- dst_write_addr  out  clog2(HEIGHT)  destination write address
- dst_write_en  out  1  destination write strobe
- dst_din  out  PARALLELISM*WIDTH  saturated result row
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse, coincident with dst_write_en

Behaviour:
- Reset values: all outputs 0 except job_ready=1; state IDLE; accumulators, count and latched dst_addr all 0.
- FSM states: IDLE, ACCUM, WRITE.
- IDLE:
  - job_ready=1.
  - On job_valid: latch dst_addr and degree, clear all lane accumulators.
  - Next state is ACCUM if degree>0, else WRITE.
- ACCUM:
  - nbr_ready=1, src_cs=1.
  - src_read_addr = nbr_addr combinationally; src_read_en = nbr_valid & nbr_ready.
  - On each handshake, every lane adds its sign-extended src_qout lane to its ACC_W accumulator; remaining count decrements.
  - When the last neighbour is accepted, next state is WRITE.
  - nbr_valid low: no read, no change; bubbles are allowed indefinitely.
- WRITE (exactly one cycle):
  - dst_cs=1, dst_write_en=1, done=1, dst_write_addr = latched dst_addr.
  - Each lane of dst_din is its accumulator clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Next state IDLE.
- Accumulator width: ACC_W cannot overflow for degree <= MAX_DEG. Saturation happens only at WRITE.
- Lane i occupies bits [i*WIDTH +: WIDTH] on both src_qout and dst_din.
- Latency: a job of degree D with no bubbles writes D+1 cycles after job acceptance. job_ready returns high on the cycle after WRITE; back-to-back jobs therefore cost D+2 cycles each.
- Degree 0: dst_din = 0, written 1 cycle after acceptance.
- Outside ACCUM: src_read_en=0 and src_cs=0. Outside WRITE: dst_write_en=0 and dst_din=0.
- Reset mid-job: the block returns to IDLE immediately. No destination write is issued and the partial sum is discarded. Neighbours already accepted are not replayed.
- Handshake values: job_dst_addr and job_degree are sampled only on the accept edge. nbr_addr must be stable while nbr_valid is high.

Decomposition:
- Package agg_pkg holds:
  - typedef of the FSM state enum;
  - a function for the lane saturating clamp (ACC_W to WIDTH);
  - a function for the lane sign-extend.
- One natural sub-module, agg_lane_acc: a per-lane accumulator with clear/add/saturated output, instantiated PARALLELISM times with a generate loop.

Test Plan:
- Basic sum (WIDTH=8, PARALLELISM=2): rows at src 3 = {lane1=10, lane0=-5} and src 7 = {20, 7}. Job dst=5, degree=2, neighbours 3 then 7 with no bubbles -> dst_write_en high in the 3rd cycle after accept, addr 5, dst_din = {30, 2}, done coincident; job_ready high the following cycle.
- Saturation: degree 3 with lane0 rows 100, 100, 100 and lane1 rows -100, -100, -100 -> dst_din = {-128, 127}.
- Degree 0: job dst=9 -> dst_din = 0 written to addr 9 one cycle after accept; src_read_en never asserted.
- Backpressure: degree 2, nbr_valid high, low, low, high -> exactly 2 reads; write 5 cycles after accept; sum correct.
- Reset mid-job: degree 4, assert rst after 2 neighbours accepted -> outputs at reset values immediately; no dst_write_en. A new degree-1 job then sums only its own row.
- Back-to-back: two degree-1 jobs with job_valid held high -> second job accepted 3 cycles after the first; results written to distinct addresses.
